// File: rtl/fifo_rd_stream.sv
// Turns a registered-read FIFO port (read enable, one-cycle data latency) into a valid/ready stream.
// Optional accepted-beat counter on m_beats_o when FIFO_RD_STREAM_CNT_EN is defined.
module fifo_rd_stream #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  fifo_rrdy_i,
    input  logic [DATA_WIDTH-1:0] fifo_dout_i,
    output logic                  fifo_re_o,
    output logic                  m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    input  logic                  m_ready_i
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [15:0]           m_beats_o
`endif
);

    typedef enum logic [1:0] {
        OccEmpty = 2'd0,
        OccOne   = 2'd1,
        OccTwo   = 2'd2
    } occ_e;

    occ_e                  occ_q, occ_d;
    logic                  inflight_q;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic                  pop;
    logic [2:0]            load;

    assign pop = valid_q & m_ready_i;

    // Words held after this edge if nothing new is read; a read is allowed while it stays <= 1.
    assign load      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_re_o = fifo_rrdy_i & ~rst_i & (load <= 3'd1);

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        unique case ({inflight_q, pop})
            2'b01: begin
                head_d = tail_q;
                occ_d  = (occ_q == OccTwo) ? OccOne : OccEmpty;
            end
            2'b10: begin
                if (occ_q == OccEmpty) begin
                    head_d = fifo_dout_i;
                    occ_d  = OccOne;
                end else begin
                    tail_d = fifo_dout_i;
                    occ_d  = OccTwo;
                end
            end
            2'b11: begin
                // Occupancy unchanged; new word goes behind whatever remains.
                if (occ_q == OccOne) begin
                    head_d = fifo_dout_i;
                end else begin
                    head_d = tail_q;
                    tail_d = fifo_dout_i;
                end
            end
            default: ;
        endcase
        valid_d = (occ_d != OccEmpty);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_q      <= OccEmpty;
            inflight_q <= 1'b0;
            valid_q    <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= fifo_re_o;
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    assign m_valid_o = valid_q;
    assign m_data_o  = head_q;

`ifdef FIFO_RD_STREAM_CNT_EN
    logic [15:0] beats_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beats_q <= 16'h0000;
        end else if (pop) begin
            beats_q <= beats_q + 16'h0001;
        end
    end

    assign m_beats_o = beats_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: upstream FIFO model, scoreboard and occupancy model.
// Covers the beat counter as well when FIFO_RD_STREAM_CNT_EN is defined.
module tb_fifo_rd_stream;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       fifo_rrdy_i;
    logic [7:0] fifo_dout_i;
    logic       fifo_re_o;
    logic       m_valid_o;
    logic [7:0] m_data_o;
    logic       m_ready_i;
`ifdef FIFO_RD_STREAM_CNT_EN
    logic [15:0] m_beats_o;
`endif

    fifo_rd_stream #(.DATA_WIDTH(8)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .fifo_rrdy_i (fifo_rrdy_i),
        .fifo_dout_i (fifo_dout_i),
        .fifo_re_o   (fifo_re_o),
        .m_valid_o   (m_valid_o),
        .m_data_o    (m_data_o),
        .m_ready_i   (m_ready_i)
`ifdef FIFO_RD_STREAM_CNT_EN
        ,
        .m_beats_o   (m_beats_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: words still in the upstream FIFO, and words read but not yet accepted.
    logic [7:0]  src[$];
    logic [7:0]  exp_q[$];
    int          outstanding = 0;
    bit          inflight_m  = 1'b0;
    int          popped      = 0;
    logic [15:0] beats_m     = 16'h0000;

    // One clock cycle: drive inputs, compare against the model, advance the model past the edge.
    task automatic cycle(input bit rst, input bit rrdy, input bit rdy,
                         output bit re_s, output bit vld_s, output logic [7:0] dat_s);
        bit exp_vld, exp_re, pop_m;
        rst_i       = rst;
        fifo_rrdy_i = rrdy && (src.size() > 0);
        m_ready_i   = rdy;
        #1;
        exp_vld = (outstanding - int'(inflight_m)) != 0;
        pop_m   = exp_vld && rdy && !rst;
        exp_re  = !rst && fifo_rrdy_i && ((outstanding - int'(pop_m)) <= 1);
        checks++;
        if (m_valid_o !== exp_vld) begin
            errors++;
            $display("FAIL valid: got %b want %b at %0t", m_valid_o, exp_vld, $time);
        end
        checks++;
        if (fifo_re_o !== exp_re) begin
            errors++;
            $display("FAIL re: got %b want %b at %0t", fifo_re_o, exp_re, $time);
        end
        if (exp_vld) begin
            checks++;
            if (m_data_o !== exp_q[0]) begin
                errors++;
                $display("FAIL data: got %h want %h at %0t", m_data_o, exp_q[0], $time);
            end
        end
        re_s  = fifo_re_o;
        vld_s = m_valid_o;
        dat_s = m_data_o;
        @(posedge clk_i);
        #1;
        fifo_dout_i = 8'($urandom);
        if (rst) begin
            exp_q.delete();
            outstanding = 0;
            inflight_m  = 1'b0;
            beats_m     = 16'h0000;
        end else begin
            if (pop_m) begin
                void'(exp_q.pop_front());
                outstanding--;
                popped++;
                beats_m = beats_m + 16'h0001;
            end
            if (re_s && src.size() > 0) begin
                fifo_dout_i = src.pop_front();
                exp_q.push_back(fifo_dout_i);
                outstanding++;
            end
            inflight_m = re_s;
        end
        checks++;
        if (outstanding > 2) begin
            errors++;
            $display("FAIL overflow: outstanding %0d want <= 2 at %0t", outstanding, $time);
        end
    endtask

    task automatic test_reset();
        bit re, v;
        logic [7:0] d;
        src.push_back(8'h11);
        cycle(1'b1, 1'b1, 1'b0, re, v, d);
        src.delete();
        cycle(1'b1, 1'b0, 1'b0, re, v, d);
        checks++;
        if (m_valid_o !== 1'b0 || m_data_o !== 8'h00 || fifo_re_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: valid %b data %h re %b want 0 00 0",
                     m_valid_o, m_data_o, fifo_re_o);
        end
    endtask

    task automatic test_single();
        bit re, v;
        logic [7:0] d;
        bit vlog[4];
        logic [7:0] dlog[4];
        src.push_back(8'hA5);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b1, 1'b1, re, v, d);
            vlog[k] = v;
            dlog[k] = d;
            if (k == 0) begin
                checks++;
                if (re !== 1'b1) begin
                    errors++;
                    $display("FAIL single_re: got %b want 1", re);
                end
            end
        end
        checks++;
        if (vlog[0] || vlog[1] || !vlog[2] || vlog[3] || dlog[2] !== 8'hA5) begin
            errors++;
            $display("FAIL single_latency: valid %b%b%b%b data %h want 0010 a5",
                     vlog[0], vlog[1], vlog[2], vlog[3], dlog[2]);
        end
    endtask

    task automatic test_stream();
        bit re, v;
        logic [7:0] d;
        int first = -1, last = -1, nvld = 0;
        for (int i = 0; i < 16; i++) src.push_back(8'(i));
        for (int k = 0; k < 24; k++) begin
            cycle(1'b0, 1'b1, 1'b1, re, v, d);
            if (v) begin
                if (first < 0) first = k;
                last = k;
                nvld++;
            end
        end
        checks++;
        if (nvld != 16 || (last - first + 1) != 16) begin
            errors++;
            $display("FAIL stream_gapless: %0d valid over span %0d want 16 over 16",
                     nvld, last - first + 1);
        end
    endtask

    task automatic test_backpressure();
        bit re, v;
        logic [7:0] d, held;
        bit have = 1'b0;
        int reads = 0;
        for (int i = 0; i < 6; i++) src.push_back(8'($urandom));
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, 1'b1, 1'b0, re, v, d);
            reads += int'(re);
            if (v) begin
                if (have) begin
                    checks++;
                    if (d !== held) begin
                        errors++;
                        $display("FAIL stall_stable: got %h want %h", d, held);
                    end
                end
                held = d;
                have = 1'b1;
            end
        end
        checks++;
        if (reads > 2) begin
            errors++;
            $display("FAIL stall_reads: got %0d want <= 2", reads);
        end
        for (int k = 0; k < 20; k++) cycle(1'b0, 1'b1, 1'b1, re, v, d);
        checks++;
        if (src.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_drain: left src %0d buf %0d want 0 0", src.size(), exp_q.size());
        end
    endtask

    task automatic test_random();
        bit re, v;
        logic [7:0] d;
        int cyc = 0;
        cycle(1'b1, 1'b0, 1'b0, re, v, d);
        popped = 0;
        for (int i = 0; i < 1000; i++) src.push_back(8'($urandom));
        while (popped < 1000 && cyc < 20000) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), re, v, d);
            cyc++;
        end
        checks++;
        if (popped != 1000 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_done: popped %0d left %0d want 1000 0", popped, exp_q.size());
        end
`ifdef FIFO_RD_STREAM_CNT_EN
        checks++;
        if (m_beats_o !== 16'd1000) begin
            errors++;
            $display("FAIL beats: got %0d want 1000", m_beats_o);
        end
        dut.beats_q = 16'hFFFE;
        beats_m     = 16'hFFFE;
        for (int i = 0; i < 3; i++) src.push_back(8'(i));
        for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, 1'b1, re, v, d);
        checks++;
        if (m_beats_o !== 16'h0001 || beats_m !== 16'h0001) begin
            errors++;
            $display("FAIL beats_wrap: got %h want 0001", m_beats_o);
        end
`endif
    endtask

    task automatic test_mid_reset();
        bit re, v;
        logic [7:0] d;
        for (int i = 0; i < 4; i++) src.push_back(8'($urandom));
        cycle(1'b0, 1'b1, 1'b0, re, v, d);
        cycle(1'b0, 1'b1, 1'b0, re, v, d);
        checks++;
        if (outstanding != 2) begin
            errors++;
            $display("FAIL midrst_setup: outstanding %0d want 2", outstanding);
        end
        cycle(1'b1, 1'b1, 1'b0, re, v, d);
        src.delete();
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 1'b1, re, v, d);
            checks++;
            if (v !== 1'b0) begin
                errors++;
                $display("FAIL midrst_flush: valid %b want 0 cycle %0d", v, k);
            end
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        fifo_rrdy_i = 1'b0;
        m_ready_i   = 1'b0;
        fifo_dout_i = 8'h00;
        @(posedge clk_i);
        #1;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
